// File: rtl/truth_table_sequencer_pkg.sv
// truth_table_sequencer_pkg: shared sequencer state encoding and default N_IN/SETTLE constants
package truth_table_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int N_IN_DEFAULT   = 2;
  localparam int SETTLE_DEFAULT = 1;
endpackage

// File: rtl/truth_table_sequencer_first_diff_encoder.sv
// first_diff_encoder: lowest set bit index of diff (idx) and any_diff=|diff; idx=0 when diff==0
module first_diff_encoder
  import truth_table_sequencer_pkg::*;
#(
  parameter int ROWS = 4,
  localparam int IW = ROWS > 1 ? $clog2(ROWS) : 1
) (
  input  logic [ROWS-1:0] diff,
  output logic [IW-1:0]   idx,
  output logic            any_diff
);
  always_comb begin
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (diff[i]) idx = IW'(i);
  end
  assign any_diff = |diff;
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps dut_in through all ROWS vectors, samples dut_out after SETTLE cycles each, reports table_out/match/err_idx with a done pulse (clk, rst, start, expected in; dut_in, busy, done, table_out, match, err_idx out)
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT,
  localparam int ROWS  = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ROWS-1:0] expected,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [ROWS-1:0] table_out,
  output logic            match,
  output logic [N_IN-1:0] err_idx
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  state_t state, state_nx;
  logic [N_IN-1:0] row, idx;
  logic [CW-1:0] cnt;
  logic [ROWS-1:0] exp_q, tbl_nx;
  logic last, final_row, any_diff;
  assign last      = cnt == CW'(SETTLE - 1);
  assign final_row = row == N_IN'(ROWS - 1);
  assign dut_in    = row;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  always_comb begin
    tbl_nx      = table_out;
    tbl_nx[row] = dut_out;
  end
  first_diff_encoder #(.ROWS(ROWS)) u_enc (
    .diff(tbl_nx ^ exp_q),
    .idx(idx),
    .any_diff(any_diff)
  );
  always_comb
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last && final_row ? DONE : RUN) : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      table_out <= '0;
      match     <= 1'b0;
      err_idx   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        exp_q     <= expected;
        table_out <= '0;
        match     <= 1'b0;
        err_idx   <= '0;
        row       <= '0;
        cnt       <= '0;
      end else if (state == RUN) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          table_out <= tbl_nx;
          if (final_row) begin
            match   <= ~any_diff;
            err_idx <= idx;
          end else row <= row + 1'b1;
        end
      end else if (state == DONE) row <= '0;
    end
  end
endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Controller that drives a combinational gate-under-test (e.g. a 2-input NAND-built function) through every input combination in order.
- Samples the gate output for each row, assembles the observed truth table and compares it with a golden table captured at start.
- Replaces hand-written per-row stimulus in exercise benches. Sits between a bench or top level and any N-input, 1-output gate module.

Parameters:
- N_IN, 2, number of gate inputs; ROWS = 2**N_IN (supported range 1..4).
- SETTLE, 1, clock cycles each input vector is held before the output is sampled (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a full sweep; honoured only in IDLE
- expected  in  ROWS  golden truth table; bit i = required output for input vector i; captured on the accepted start
- dut_in  out  N_IN  vector driven to the gate under test; MSB is the first-listed input (a)
- dut_out  in  1  gate output (s)
- busy  out  1  high from the cycle after start acceptance until DONE is left
- done  out  1  one-cycle pulse when results are valid
- table_out  out  ROWS  observed truth table; bit i = dut_out sampled for vector i
- match  out  1  table_out == captured expected; valid from done, held until the next accepted start
- err_idx  out  N_IN  lowest row index where observed differs from expected; 0 when match=1

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-sweep):
  - state=IDLE; dut_in=0, busy=0, done=0, table_out=0, match=0, err_idx=0.
  - Internal row index, settle counter and expected copy cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture expected, clear table_out/match/err_idx, row=0, cnt=0, dut_in=0, go RUN.
  - start=0: hold all outputs, including the previous results.
- RUN:
  - dut_in = row (registered).
  - Each edge with cnt<SETTLE-1: cnt++.
  - Edge with cnt==SETTLE-1: table_out[row] <= dut_out, cnt=0.
    - row==ROWS-1: go DONE.
    - Otherwise row++ and dut_in updates at the same edge.
  - start is ignored in RUN; no restart, no queuing.
- DONE (exactly one cycle):
  - done=1, busy=1.
  - match and err_idx registered at entry into DONE, computed from the complete table_out including the last sample.
  - Next edge: IDLE, done=0, busy=0. dut_in returns to 0. Results are held.
- Latency: done is high in the cycle beginning ROWS*SETTLE edges after the start-accept edge. With N_IN=2, SETTLE=1: start accepted at E0, samples at E1..E4, done high between E4 and E5.
- Sampling rules:
  - dut_out is sampled only at the final settle edge of each row.
  - Glitches or changes at earlier edges do not affect the result.
- err_idx: priority encoder over (table_out XOR expected_q), lowest index wins.
- start held high continuously: a new sweep begins at the first IDLE edge after DONE, i.e. back-to-back sweeps with one IDLE cycle between them.
- start and rst asserted at the same edge: reset wins.
- expected may change during RUN; only the captured copy is used.

Decomposition:
- Shared header: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default N_IN/SETTLE constants, reused by later sequencer exercises.
- One natural sub-module: first_diff_encoder. Combinational, parameterised on ROWS; takes the XOR vector and returns err_idx plus an any_diff flag; match = ~any_diff.
- Counter and FSM stay in the top module.

Test Plan:
- Reset then idle: rst high 2 cycles, start=0 for 5 cycles -> busy=0, done=0, dut_in=0, table_out=0 throughout.
- Correct gate: gate s = ~(~a&b) instantiated, N_IN=2, SETTLE=1, expected=4'b1101, start pulse -> dut_in steps 0,1,2,3 on consecutive cycles; done 4 edges after accept; table_out=4'b1101, match=1, err_idx=0.
- Wrong expectation: same gate, expected=4'b1111 -> table_out=4'b1101, match=0, err_idx=1.
- SETTLE=3: same gate and expected=4'b1101 -> each dut_in value held 3 cycles; done 12 edges after accept; match=1. Forcing dut_out wrong only during the first 2 cycles of each row still gives match=1.
- Start ignored and reset mid-run:
  - Pulse start again at row 2 -> no restart; done timing unchanged.
  - New sweep with rst at row 1 -> next cycle busy=0, dut_in=0, table_out=0, no done pulse.
- Start held high: start=1 for 12 cycles -> two complete sweeps, done pulses 6 edges apart with one IDLE cycle between them; results identical.
